// File: rtl/riscv_pkg.sv
// Shared RV32 store-path definitions: store funct3 encodings, buffered store entry,
// and the helpers that turn an execute-stage store into a word-aligned memory write.
package riscv_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } st_entry_t;

  localparam int unsigned ST_ENTRY_W = $bits(st_entry_t);

  // Misaligned SH/SW or an unknown width is a fault.
  function automatic logic store_bad(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_SB:   return 1'b0;
      F3_SH:   return off[0];
      F3_SW:   return |off;
      default: return 1'b1;
    endcase
  endfunction

  // Only meaningful for legal stores; data is replicated across every lane so
  // memory just needs the byte enables.
  function automatic st_entry_t store_fmt(input logic [2:0]  f3,
                                          input logic [31:0] addr,
                                          input logic [31:0] data);
    st_entry_t e;
    e.waddr = addr[31:2];
    case (f3)
      F3_SB: begin
        e.be    = 4'b0001 << addr[1:0];
        e.wdata = {4{data[7:0]}};
      end
      F3_SH: begin
        e.be    = addr[1] ? 4'b1100 : 4'b0011;
        e.wdata = {2{data[15:0]}};
      end
      default: begin
        e.be    = 4'b1111;
        e.wdata = data;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/store_unit.sv
// Store buffer: formats and alignment-checks execute-stage stores, queues them,
// and drains them in program order to data memory over req/gnt.
module store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [2:0]             st_funct3,
  input  logic [XLEN-1:0]        st_addr,
  input  logic [XLEN-1:0]        st_data,
  output logic                   st_fault,
  output logic                   mem_req,
  input  logic                   mem_gnt,
  output logic [XLEN-1:0]        mem_addr,
  output logic [XLEN-1:0]        mem_wdata,
  output logic [3:0]             mem_be,
  output logic                   sb_empty,
  output logic [$clog2(DEPTH):0] sb_count
);

  logic      accept, bad, push, pop;
  logic      fifo_full, fifo_empty;
  logic      fault_q;
  st_entry_t entry, head;

  assign accept = st_valid & st_ready;
  assign bad    = store_bad(st_funct3, st_addr[1:0]);
  assign entry  = store_fmt(st_funct3, st_addr, st_data);
  assign push   = accept & ~bad;
  assign pop    = mem_req & mem_gnt;

  sync_fifo #(
    .Width (ST_ENTRY_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (sb_count)
  );

  // A grant popping a full buffer does not free the slot until the next cycle.
  assign st_ready = ~fifo_full;
  assign sb_empty = fifo_empty;

  // Head fields are forced to zero when idle so stale storage never leaks out.
  always_comb begin
    mem_req   = ~fifo_empty;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (mem_req) begin
      mem_addr  = {head.waddr, 2'b00};
      mem_wdata = head.wdata;
      mem_be    = head.be;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= accept & bad;
    end
  end

  assign st_fault = fault_q;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed vector table, backpressure/reset
// sequences, and a randomized run against a queue-based reference model.
module tb_store_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [2:0]  st_funct3 = '0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        st_fault;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        sb_empty;
  logic [1:0]  sb_count;

  int tests = 0;
  int failed = 0;

  store_unit #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_funct3 (st_funct3),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_fault  (st_fault),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .sb_empty  (sb_empty),
    .sb_count  (sb_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  // Reference: size in bytes = 2^funct3, lane i carries data byte (i mod size).
  function automatic void model_fmt(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] d, output logic legal,
                                    output exp_t e);
    int size;
    int be_int;
    e.addr  = a & 32'hFFFF_FFFC;
    e.wdata = '0;
    e.be    = '0;
    legal   = 1'b0;
    if (f3 <= 3'd2) begin
      size  = 1 << f3;
      legal = ((a % size) == 0);
      be_int = ((1 << size) - 1) << a[1:0];
      e.be = be_int[3:0];
      for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = d[8*(i % size) +: 8];
    end
  endfunction

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic g);
    st_valid  = v;
    st_funct3 = f3;
    st_addr   = a;
    st_data   = d;
    mem_gnt   = g;
  endtask

  vec_t vecs[12];
  exp_t q[$];
  exp_t e;
  logic legal, acc, fault_exp;

  initial begin
    vecs[0]  = '{3'b000, 32'h103, 32'hAABBCCDD, 1'b0, 32'h100, 32'hDDDDDDDD, 4'b1000};
    vecs[1]  = '{3'b000, 32'h100, 32'hAABBCCDD, 1'b0, 32'h100, 32'hDDDDDDDD, 4'b0001};
    vecs[2]  = '{3'b000, 32'h101, 32'hAABBCCDD, 1'b0, 32'h100, 32'hDDDDDDDD, 4'b0010};
    vecs[3]  = '{3'b000, 32'h102, 32'hAABBCCDD, 1'b0, 32'h100, 32'hDDDDDDDD, 4'b0100};
    vecs[4]  = '{3'b001, 32'h202, 32'h00001234, 1'b0, 32'h200, 32'h12341234, 4'b1100};
    vecs[5]  = '{3'b001, 32'h200, 32'hFFFF5678, 1'b0, 32'h200, 32'h56785678, 4'b0011};
    vecs[6]  = '{3'b010, 32'h300, 32'hCAFEF00D, 1'b0, 32'h300, 32'hCAFEF00D, 4'b1111};
    vecs[7]  = '{3'b010, 32'h301, 32'h11111111, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[8]  = '{3'b001, 32'h201, 32'h22222222, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[9]  = '{3'b011, 32'h400, 32'h33333333, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[10] = '{3'b010, 32'h302, 32'h44444444, 1'b1, 32'h0, 32'h0, 4'b0000};
    vecs[11] = '{3'b111, 32'h500, 32'h55555555, 1'b1, 32'h0, 32'h0, 4'b0000};

    // Reset / idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_st_ready", st_ready, 1);
    check("rst_sb_empty", sb_empty, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_sb_count", sb_count, 0);
    check("rst_st_fault", st_fault, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_be", mem_be, 0);

    // Directed vectors, granted immediately
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(1'b1, vecs[i].f3, vecs[i].addr, vecs[i].data, 1'b1);
      @(negedge clk);
      check($sformatf("v%0d_fault", i), st_fault, vecs[i].fault);
      check($sformatf("v%0d_req", i), mem_req, !vecs[i].fault);
      check($sformatf("v%0d_count", i), sb_count, vecs[i].fault ? 0 : 1);
      if (!vecs[i].fault) begin
        check($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
        check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
        check($sformatf("v%0d_be", i), mem_be, vecs[i].e_be);
      end
      drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      check($sformatf("v%0d_fault_pulse", i), st_fault, 0);
      check($sformatf("v%0d_drained", i), sb_empty, 1);
    end

    // Backpressure: three SW with no grant
    drive(1'b1, 3'b010, 32'h400, 32'hA0A0A0A0, 1'b0);
    @(negedge clk);
    check("bp_ready1", st_ready, 1);
    drive(1'b1, 3'b010, 32'h404, 32'hB0B0B0B0, 1'b0);
    @(negedge clk);
    check("bp_ready_full", st_ready, 0);
    check("bp_count2", sb_count, 2);
    check("bp_head_addr", mem_addr, 32'h400);
    drive(1'b1, 3'b010, 32'h408, 32'hC0C0C0C0, 1'b0);
    @(negedge clk);
    check("bp_hold_addr", mem_addr, 32'h400);
    check("bp_hold_wdata", mem_wdata, 32'hA0A0A0A0);
    check("bp_hold_count", sb_count, 2);
    mem_gnt = 1'b1;
    @(negedge clk);
    // A popped, C blocked because ready was 0 at that edge
    check("bp_pop1_addr", mem_addr, 32'h404);
    check("bp_pop1_count", sb_count, 1);
    check("bp_pop1_ready", st_ready, 1);
    @(negedge clk);
    // Simultaneous pop of B and push of C
    check("pp_count", sb_count, 1);
    check("pp_addr", mem_addr, 32'h408);
    check("pp_wdata", mem_wdata, 32'hC0C0C0C0);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    check("pp_drained", sb_empty, 1);

    // Async reset mid-drain
    drive(1'b1, 3'b010, 32'h600, 32'h12345678, 1'b0);
    @(negedge clk);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    check("rd_req_before", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rd_req_dropped", mem_req, 0);
    check("rd_sb_empty", sb_empty, 1);
    check("rd_sb_count", sb_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rd_after_req", mem_req, 0);

    // Randomized run against the queue model
    q.delete();
    fault_exp = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      check("rnd_ready", st_ready, q.size() < DEPTH);
      check("rnd_req", mem_req, q.size() != 0);
      check("rnd_empty", sb_empty, q.size() == 0);
      check("rnd_count", sb_count, q.size());
      check("rnd_fault", st_fault, fault_exp);
      if (q.size() != 0) begin
        check("rnd_addr", mem_addr, q[0].addr);
        check("rnd_wdata", mem_wdata, q[0].wdata);
        check("rnd_be", mem_be, {28'h0, q[0].be});
      end
      drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 5)), $urandom, $urandom,
            $urandom_range(0, 1) == 1);
      model_fmt(st_funct3, st_addr, st_data, legal, e);
      acc = st_valid && (q.size() < DEPTH);
      fault_exp = acc && !legal;
      if (mem_gnt && q.size() != 0) void'(q.pop_front());
      if (acc && legal) q.push_back(e);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
